// File: rtl/alu_system_sequencer.sv
// Hardwired fetch/decode/execute controller for the ALU_System datapath.
// Fetches a 16-bit instruction as two byte reads at PC, then executes it in one or two cycles.
module alu_system_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  ALUOutFlag,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RSel,
   output logic [3:0]  RF_TSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [1:0]  ARF_FunSel,
   output logic [3:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Enable,
   output logic [1:0]  IR_Funsel,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted,
   output logic        Illegal,
   output logic [2:0]  State
);

   typedef enum logic [2:0] {
      StInit   = 3'd0,
      StFetchL = 3'd1,
      StFetchH = 3'd2,
      StExec1  = 3'd3,
      StExec2  = 3'd4,
      StHalt   = 3'd5
   } state_e;

   localparam logic [3:0] OpAlu = 4'h0;
   localparam logic [3:0] OpLdi = 4'h1;
   localparam logic [3:0] OpLd  = 4'h2;
   localparam logic [3:0] OpSt  = 4'h3;
   localparam logic [3:0] OpBra = 4'h4;
   localparam logic [3:0] OpBz  = 4'h5;
   localparam logic [3:0] OpHlt = 4'hF;

   localparam logic [1:0] FsInc   = 2'b01;
   localparam logic [1:0] FsLoad  = 2'b10;
   localparam logic [1:0] FsClear = 2'b11;

   localparam logic [1:0] SelAluOut = 2'b00;
   localparam logic [1:0] SelMemOut = 2'b01;
   localparam logic [1:0] SelImm    = 2'b10;

   state_e state_q, state_d;

   logic [3:0] op;
   logic [1:0] rd;
   logic [1:0] ra;
   logic [1:0] rb;
   logic [3:0] fn;
   logic       zero_flag;
   logic       unused_flags;

   assign op           = IROut[15:12];
   assign rd           = IROut[11:10];
   assign ra           = IROut[9:8];
   assign rb           = IROut[3:2];
   assign fn           = IROut[7:4];
   assign zero_flag    = ALUOutFlag[3];
   assign unused_flags = ^ALUOutFlag[2:0];

   function automatic logic [3:0] onehot(input logic [1:0] r);
      onehot = 4'b1000 >> r;
   endfunction

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit:   state_d = StFetchL;
         StFetchL: state_d = StFetchH;
         StFetchH: state_d = StExec1;
         StExec1: begin
            case (op)
               OpLd, OpSt: state_d = StExec2;
               OpHlt:      state_d = StHalt;
               default:    state_d = StFetchL;
            endcase
         end
         StExec2:  state_d = StFetchL;
         StHalt:   state_d = StHalt;
         default:  state_d = StInit;
      endcase
   end

   always_comb begin
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = 2'b00;
      RF_RSel     = 4'b0000;
      RF_TSel     = 4'b0000;
      ALU_FunSel  = 4'b0000;
      ARF_OutCSel = 2'b00;
      ARF_OutDSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RegSel  = 4'b0000;
      IR_LH       = 1'b0;
      IR_Enable   = 1'b0;
      IR_Funsel   = 2'b00;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      Halted      = 1'b0;
      Illegal     = 1'b0;
      case (state_q)
         StInit: begin
            RF_FunSel  = FsClear;
            RF_RSel    = 4'b1111;
            ARF_FunSel = FsClear;
            ARF_RegSel = 4'b1110;
         end
         StFetchL, StFetchH: begin
            // Byte read at PC into the selected IR half, PC post-incremented.
            Mem_CS     = 1'b0;
            IR_Enable  = 1'b1;
            IR_Funsel  = FsLoad;
            IR_LH      = (state_q == StFetchH);
            ARF_FunSel = FsInc;
            ARF_RegSel = 4'b1000;
         end
         StExec1: begin
            case (op)
               OpAlu: begin
                  RF_OutASel = {1'b0, ra};
                  RF_OutBSel = {1'b0, rb};
                  ALU_FunSel = fn;
                  MuxASel    = SelAluOut;
                  RF_FunSel  = FsLoad;
                  RF_RSel    = onehot(rd);
               end
               OpLdi: begin
                  MuxASel   = SelImm;
                  RF_FunSel = FsLoad;
                  RF_RSel   = onehot(rd);
               end
               OpLd, OpSt: begin
                  MuxBSel    = SelImm;
                  ARF_FunSel = FsLoad;
                  ARF_RegSel = 4'b0100;
               end
               OpBra: begin
                  MuxBSel    = SelImm;
                  ARF_FunSel = FsLoad;
                  ARF_RegSel = 4'b1000;
               end
               OpBz: begin
                  // Flags come from the last ALU write, not from this instruction.
                  if (zero_flag) begin
                     MuxBSel    = SelImm;
                     ARF_FunSel = FsLoad;
                     ARF_RegSel = 4'b1000;
                  end
               end
               OpHlt: begin
               end
               default: Illegal = 1'b1;
            endcase
         end
         StExec2: begin
            case (op)
               OpLd: begin
                  Mem_CS      = 1'b0;
                  ARF_OutDSel = 2'b01;
                  MuxASel     = SelMemOut;
                  RF_FunSel   = FsLoad;
                  RF_RSel     = onehot(rd);
               end
               OpSt: begin
                  Mem_CS      = 1'b0;
                  Mem_WR      = 1'b1;
                  ARF_OutDSel = 2'b01;
                  RF_OutASel  = {1'b0, ra};
                  ALU_FunSel  = 4'b0000;
               end
               default: begin
               end
            endcase
         end
         StHalt:  Halted = 1'b1;
         default: begin
         end
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_alu_system_sequencer.sv
// Bench for alu_system_sequencer: a behavioural datapath driven by the DUT, checked per instruction
// against an instruction-level model of the machine through a scoreboard queue.
module tb_alu_system_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [2:0]  RF_OutASel, RF_OutBSel, State;
   logic [1:0]  RF_FunSel, ARF_FunSel, ARF_OutCSel, ARF_OutDSel, IR_Funsel, MuxASel, MuxBSel;
   logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RegSel;
   logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted, Illegal;

   always #5 Clock = ~Clock;

   alu_system_sequencer dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
      .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
      .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
      .MuxCSel(MuxCSel), .Halted(Halted), .Illegal(Illegal), .State(State)
   );

   // ---------------- behavioural datapath ----------------
   logic [7:0]  dmem [256];
   logic [7:0]  rf [4];
   logic [7:0]  pc, ar, sp;
   logic [15:0] ir;
   logic        zf;
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr, ld_data;
   logic [7:0]  rf_a, rf_b, arf_c, arf_d, alu_a, alu_out, mem_out, muxa, muxb;

   function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a,
                                         input logic [7:0] b);
      case (f)
         4'h0:    return a;
         4'h1:    return b;
         4'h4:    return a + b;
         4'h6:    return a - b;
         4'h7:    return a & b;
         4'h8:    return a | b;
         4'h9:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   function automatic logic [7:0] arf_pick(input logic [1:0] s, input logic [7:0] p,
                                           input logic [7:0] a, input logic [7:0] st);
      case (s)
         2'b00:   return p;
         2'b01:   return a;
         2'b10:   return st;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] reg_next(input logic [7:0] v, input logic [1:0] fs,
                                           input logic [7:0] d);
      case (fs)
         2'b00:   return v - 8'd1;
         2'b01:   return v + 8'd1;
         2'b10:   return d;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] mux4(input logic [1:0] s, input logic [7:0] alu,
                                       input logic [7:0] mem, input logic [7:0] imm,
                                       input logic [7:0] c);
      case (s)
         2'b00:   return alu;
         2'b01:   return mem;
         2'b10:   return imm;
         default: return c;
      endcase
   endfunction

   assign rf_a       = rf[RF_OutASel[1:0]];
   assign rf_b       = rf[RF_OutBSel[1:0]];
   assign arf_c      = arf_pick(ARF_OutCSel, pc, ar, sp);
   assign arf_d      = arf_pick(ARF_OutDSel, pc, ar, sp);
   assign alu_a      = MuxCSel ? arf_c : rf_a;
   assign alu_out    = alu_fn(ALU_FunSel, alu_a, rf_b);
   assign mem_out    = dmem[arf_d];
   assign muxa       = mux4(MuxASel, alu_out, mem_out, ir[7:0], arf_c);
   assign muxb       = mux4(MuxBSel, alu_out, mem_out, ir[7:0], arf_c);
   assign IROut      = ir;
   assign ALUOutFlag = {zf, 3'b000};

   always @(posedge Clock) begin
      if (ld_en) begin
         dmem[ld_addr] <= ld_data;
         zf <= 1'b0;
      end else if (!Mem_CS && Mem_WR) begin
         dmem[arf_d] <= alu_out;
      end
      if (IR_Enable && IR_Funsel == 2'b10) begin
         if (IR_LH) ir[15:8] <= mem_out;
         else       ir[7:0]  <= mem_out;
      end
      for (int i = 0; i < 4; i++) begin
         if (RF_RSel[3-i]) rf[i] <= reg_next(rf[i], RF_FunSel, muxa);
      end
      if (ARF_RegSel[3]) pc <= reg_next(pc, ARF_FunSel, muxb);
      if (ARF_RegSel[2]) ar <= reg_next(ar, ARF_FunSel, muxb);
      if (ARF_RegSel[1]) sp <= reg_next(sp, ARF_FunSel, muxb);
      if (!ld_en && RF_FunSel == 2'b10 && RF_RSel != 4'b0000 && MuxASel == 2'b00)
         zf <= (alu_out == 8'h00);
   end

   // ---------------- scoreboard and instruction-level model ----------------
   typedef struct {
      logic [31:0] rf;
      logic [7:0]  pc;
      logic [7:0]  ar;
      int          cyc;
      int          ill;
      int          wr;
      logic        halt;
      logic        st;
      logic [7:0]  st_addr;
      logic [7:0]  st_data;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] m_mem [256];
   logic [7:0] m_rf [4];
   logic [7:0] m_pc, m_ar;
   logic       m_z = 1'b0;
   logic [3:0] fns [8] = '{4'h0, 4'h1, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_pc = 8'h00;
      m_ar = 8'h00;
   endtask

   task automatic model_step(output bit halted);
      exp_t       e;
      logic [15:0] ins;
      logic [7:0]  a1, imm, r;
      logic [3:0]  op, fn;
      logic [1:0]  rd, ra, rb;
      a1  = m_pc + 8'd1;
      ins = {m_mem[a1], m_mem[m_pc]};
      m_pc = m_pc + 8'd2;
      op = ins[15:12]; rd = ins[11:10]; ra = ins[9:8]; rb = ins[3:2];
      fn = ins[7:4];   imm = ins[7:0];
      e.cyc = 3; e.ill = 0; e.wr = 0; e.halt = 1'b0; e.st = 1'b0;
      e.st_addr = 8'h00; e.st_data = 8'h00;
      case (op)
         4'h0: begin
            r = alu_fn(fn, m_rf[ra], m_rf[rb]);
            m_rf[rd] = r;
            m_z = (r == 8'h00);
         end
         4'h1: m_rf[rd] = imm;
         4'h2: begin
            m_ar = imm; m_rf[rd] = m_mem[imm]; e.cyc = 4;
         end
         4'h3: begin
            m_ar = imm; m_mem[imm] = m_rf[ra]; e.cyc = 4; e.wr = 1;
            e.st = 1'b1; e.st_addr = imm; e.st_data = m_rf[ra];
         end
         4'h4: m_pc = imm;
         4'h5: if (m_z) m_pc = imm;
         4'hF: e.halt = 1'b1;
         default: e.ill = 1;
      endcase
      e.rf = {m_rf[0], m_rf[1], m_rf[2], m_rf[3]};
      e.pc = m_pc;
      e.ar = m_ar;
      exp_q.push_back(e);
      halted = e.halt;
   endtask

   task automatic model_run();
      bit h = 1'b0;
      for (int k = 0; k < 200 && !h; k++) model_step(h);
   endtask

   // ---------------- monitor ----------------
   logic [2:0] prev = 3'd0;
   int         cyc = 0, ill = 0, wr = 0, tsel = 0;
   exp_t       e_m;

   task automatic complete();
      if (exp_q.size() == 0) begin
         check("unexpected_completion", exp_q.size(), 1);
      end else begin
         e_m = exp_q.pop_front();
         check("rf", {rf[0], rf[1], rf[2], rf[3]}, e_m.rf);
         check("pc", 32'(pc), 32'(e_m.pc));
         check("ar_sp", {16'h0, ar, sp}, {16'h0, e_m.ar, 8'h00});
         check("cycles", cyc, e_m.cyc);
         check("illegal_pulses", ill, e_m.ill);
         check("mem_wr_cycles", wr, e_m.wr);
         check("t_sel", tsel, 0);
         check("halted", 32'(Halted), 32'(e_m.halt));
         if (e_m.st) check("st_mem", 32'(dmem[e_m.st_addr]), 32'(e_m.st_data));
      end
   endtask

   always @(negedge Clock) begin
      if (State == 3'd1) begin
         if (prev == 3'd3 || prev == 3'd4) complete();
         cyc  = 1;
         ill  = Illegal ? 1 : 0;
         wr   = (!Mem_CS && Mem_WR) ? 1 : 0;
         tsel = (RF_TSel != 4'b0000) ? 1 : 0;
      end else if (State == 3'd5) begin
         if (prev == 3'd3) complete();
      end else if (State inside {3'd2, 3'd3, 3'd4}) begin
         cyc++;
         if (Illegal) ill++;
         if (!Mem_CS && Mem_WR) wr++;
         if (RF_TSel != 4'b0000) tsel++;
      end
      prev = State;
   end

   // ---------------- stimulus ----------------
   function automatic logic [15:0] enc_alu(input logic [1:0] rd, input logic [1:0] ra,
                                           input logic [1:0] rb, input logic [3:0] fn);
      return {4'h0, rd, ra, fn, rb, 2'b00};
   endfunction

   function automatic logic [15:0] enc_imm(input logic [3:0] op, input logic [1:0] rd,
                                           input logic [1:0] ra, input logic [7:0] imm);
      return {op, rd, ra, imm};
   endfunction

   task automatic put_ins(input logic [7:0] a, input logic [15:0] ins);
      logic [7:0] a1;
      a1 = a + 8'd1;
      m_mem[a]  = ins[7:0];
      m_mem[a1] = ins[15:8];
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 128; a++) m_mem[a] = 8'hFF;
      for (int a = 128; a < 256; a++) m_mem[a] = 8'($urandom);
   endtask

   // Copies the model memory into the datapath one byte per cycle; DUT must be idle.
   task automatic load_mem();
      for (int a = 0; a < 256; a++) begin
         ld_en = 1'b1; ld_addr = 8'(a); ld_data = m_mem[a];
         @(negedge Clock);
      end
      ld_en = 1'b0;
      m_z = 1'b0;
   endtask

   task automatic gen_random(input int unsigned n);
      logic [1:0] rd, ra, rb;
      logic [7:0] tgt;
      int unsigned kind;
      clear_mem();
      for (int unsigned i = 0; i < n; i++) begin
         rd = 2'($urandom); ra = 2'($urandom); rb = 2'($urandom);
         tgt = 8'(2 * $urandom_range(n, i + 1));
         kind = $urandom_range(9, 0);
         case (kind)
            0, 1:    put_ins(8'(2 * i), enc_alu(rd, ra, rb, fns[$urandom_range(7, 0)]));
            2:       put_ins(8'(2 * i), enc_imm(4'h1, rd, 2'b00, 8'($urandom)));
            3:       put_ins(8'(2 * i), enc_imm(4'h2, rd, 2'b00, 8'($urandom_range(255, 128))));
            4:       put_ins(8'(2 * i), enc_imm(4'h3, 2'b00, ra, 8'($urandom_range(255, 128))));
            5:       put_ins(8'(2 * i), enc_imm(4'h4, 2'b00, 2'b00, tgt));
            6, 7:    put_ins(8'(2 * i), enc_imm(4'h5, 2'b00, 2'b00, tgt));
            8:       put_ins(8'(2 * i), {4'($urandom_range(14, 6)), 12'($urandom)});
            default: put_ins(8'(2 * i), enc_alu(rd, ra, ra, 4'h6));
         endcase
      end
      put_ins(8'(2 * n), 16'hF000);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, 32'(State), 0);
      check({tag, "_halted"}, 32'(Halted), 0);
      check({tag, "_illegal"}, 32'(Illegal), 0);
      check({tag, "_rf_rsel"}, 32'(RF_RSel), 32'hF);
      check({tag, "_arf_regsel"}, 32'(ARF_RegSel), 32'hE);
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge Clock);
         c++;
      end
      check("drain_queue", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic halt_check(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge Clock);
         check("halt_state", 32'(State), 5);
         check("halt_flag", 32'(Halted), 1);
         check("halt_pc", 32'(pc), 32'(m_pc));
      end
   endtask

   initial begin
      int c;
      Reset = 1'b0;
      // Directed program: LDI, ALU add, ST/LD round trip, BZ taken and not taken, illegal, HLT.
      clear_mem();
      put_ins(8'h00, enc_imm(4'h1, 2'd2, 2'd0, 8'h1A));
      put_ins(8'h02, enc_imm(4'h1, 2'd0, 2'd0, 8'h22));
      put_ins(8'h04, enc_imm(4'h1, 2'd1, 2'd0, 8'h29));
      put_ins(8'h06, enc_alu(2'd2, 2'd0, 2'd1, 4'h4));
      put_ins(8'h08, enc_imm(4'h3, 2'd0, 2'd0, 8'h80));
      put_ins(8'h0A, enc_imm(4'h2, 2'd3, 2'd0, 8'h80));
      put_ins(8'h0C, enc_alu(2'd1, 2'd0, 2'd0, 4'h6));
      put_ins(8'h0E, enc_imm(4'h5, 2'd0, 2'd0, 8'h40));
      put_ins(8'h40, 16'h9123);
      put_ins(8'h42, enc_alu(2'd0, 2'd0, 2'd1, 4'h4));
      put_ins(8'h44, enc_imm(4'h5, 2'd0, 2'd0, 8'h10));
      put_ins(8'h46, 16'hF000);
      load_mem();
      @(negedge Clock);
      check_reset("por");
      model_reset();
      model_run();
      Reset = 1'b1;
      drain(2000);
      check("dir_r3", 32'(rf[2]), 32'h4B);
      check("dir_r4", 32'(rf[3]), 32'h22);
      check("dir_mem80", 32'(dmem[8'h80]), 32'h22);
      check("dir_pc", 32'(pc), 32'h48);
      halt_check(12);

      // Reset out of HALT, then again in the first FETCH_H.
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      check_reset("rst_halt");
      Reset = 1'b1;
      c = 0;
      do begin
         @(negedge Clock);
         c++;
      end while (State != 3'd2 && c < 20);
      check("reach_fetch_h", 32'(State), 2);
      Reset = 1'b0;
      @(negedge Clock);
      check_reset("rst_fetch_h");
      model_reset();
      model_run();
      Reset = 1'b1;
      drain(2000);
      halt_check(3);

      for (int r = 0; r < 4; r++) begin
         gen_random(40);
         load_mem();
         Reset = 1'b0;
         @(negedge Clock);
         check_reset("rst_round");
         model_reset();
         model_run();
         Reset = 1'b1;
         drain(3000);
         halt_check(3);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
